// File: rtl/friscv_icache_linefill.sv
// ============================================================================
// Module   : friscv_icache_linefill
// Brief    : I-cache miss line-fill engine (single AXI4 INCR burst per line)
//            and full-cache flush sweeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module friscv_icache_linefill #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int AXI_ID_W     = 8,
  parameter int AXI_ID       = 0,
  parameter int AXI_DATA_W   = 32,
  parameter int CACHE_LINE_W = 128,
  parameter int CACHE_DEPTH  = 512,
  localparam int IDX_W       = $clog2(CACHE_DEPTH)
)(
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    flush_req,
  output logic                    flush_ack,
  output logic                    flushing,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [ADDR_W-1:0]       miss_addr,
  output logic                    miss_err,
  output logic                    mem_arvalid,
  input  logic                    mem_arready,
  output logic [ADDR_W-1:0]       mem_araddr,
  output logic [7:0]              mem_arlen,
  output logic [2:0]              mem_arsize,
  output logic [1:0]              mem_arburst,
  output logic                    mem_arlock,
  output logic [3:0]              mem_arcache,
  output logic [2:0]              mem_arprot,
  output logic [3:0]              mem_arqos,
  output logic [3:0]              mem_arregion,
  output logic [AXI_ID_W-1:0]     mem_arid,
  input  logic                    mem_rvalid,
  output logic                    mem_rready,
  input  logic [AXI_ID_W-1:0]     mem_rid,
  input  logic [1:0]              mem_rresp,
  input  logic [AXI_DATA_W-1:0]   mem_rdata,
  input  logic                    mem_rlast,
  output logic                    cache_wen,
  output logic [ADDR_W-1:0]       cache_waddr,
  output logic [CACHE_LINE_W-1:0] cache_wdata,
  output logic                    cache_clr,
  output logic [IDX_W-1:0]        cache_clr_idx
);

  localparam int NB_BEATS   = CACHE_LINE_W / AXI_DATA_W;
  localparam int LINE_OFF_W = $clog2(CACHE_LINE_W / 8);
  localparam int CNT_W      = $clog2(NB_BEATS + 1);

  localparam logic [CNT_W-1:0] c_NB_BEATS  = CNT_W'(NB_BEATS);
  localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(NB_BEATS - 1);
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(CACHE_DEPTH - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_AR    = 3'd1;
  localparam logic [2:0] c_RDATA = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_FLUSH = 3'd4;
  localparam logic [2:0] c_FACK  = 3'd5;

  logic [2:0]              r_state;
  logic [2:0]              w_next;
  logic [ADDR_W-1:0]       r_addr;
  logic [CACHE_LINE_W-1:0] r_buf;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_armed;
  logic                    w_flush_start;
  logic [ADDR_W-1:0]       w_aligned;

  logic                    w_unused_rid;
  logic [XLEN-1:0]         w_unused_xlen;
  assign w_unused_rid  = ^mem_rid;
  assign w_unused_xlen = '0;

  // A flush is edge-armed: flush_req must be seen low before it can start again.
  assign w_flush_start = flush_req & r_armed;
  assign w_aligned     = {miss_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_IDLE;
    end else if (srst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_flush_start)                 w_next = c_FLUSH;
        else if (miss_valid && !flush_req) w_next = c_AR;
      end
      c_AR:    if (mem_arready)             w_next = c_RDATA;
      c_RDATA: if (mem_rvalid && mem_rlast) w_next = c_WRITE;
      c_WRITE: w_next = w_flush_start ? c_FLUSH : c_IDLE;
      c_FLUSH: if (r_idx == c_LAST_IDX)     w_next = c_FACK;
      c_FACK:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    miss_ready    = 1'b0;
    miss_err      = 1'b0;
    flush_ack     = 1'b0;
    flushing      = 1'b0;
    mem_arvalid   = 1'b0;
    mem_araddr    = '0;
    mem_arlen     = '0;
    mem_arsize    = '0;
    mem_arburst   = '0;
    mem_arlock    = 1'b0;
    mem_arcache   = '0;
    mem_arprot    = '0;
    mem_arqos     = '0;
    mem_arregion  = '0;
    mem_arid      = '0;
    mem_rready    = 1'b0;
    cache_wen     = 1'b0;
    cache_waddr   = '0;
    cache_wdata   = '0;
    cache_clr     = 1'b0;
    cache_clr_idx = '0;
    case (r_state)
      c_IDLE: miss_ready = !flush_req;
      c_AR: begin
        mem_arvalid = 1'b1;
        mem_araddr  = r_addr;
        mem_arlen   = 8'(NB_BEATS - 1);
        mem_arsize  = 3'($clog2(AXI_DATA_W / 8));
        mem_arburst = 2'b01;
        mem_arid    = AXI_ID_W'(AXI_ID);
      end
      c_RDATA: mem_rready = 1'b1;
      c_WRITE: begin
        if (r_err) begin
          miss_err = 1'b1;
        end else begin
          cache_wen   = 1'b1;
          cache_waddr = r_addr;
          cache_wdata = r_buf;
        end
      end
      c_FLUSH: begin
        flushing      = 1'b1;
        cache_clr     = 1'b1;
        cache_clr_idx = r_idx;
      end
      c_FACK:  flush_ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_armed <= 1'b1;
    end else if (srst) begin
      r_addr  <= '0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_armed <= 1'b1;
    end else begin
      if (r_state != c_FLUSH && w_next == c_FLUSH) r_armed <= 1'b0;
      else if (!flush_req)                         r_armed <= 1'b1;

      if (r_state == c_IDLE && w_next == c_AR) begin
        r_addr <= w_aligned;
        r_buf  <= '0;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end

      if (r_state == c_RDATA && mem_rvalid) begin
        // Beats past the line length are dropped and poison the fill.
        if (r_cnt < c_NB_BEATS) begin
          for (int k = 0; k < NB_BEATS; k++) begin
            if (r_cnt == CNT_W'(k)) r_buf[k*AXI_DATA_W +: AXI_DATA_W] <= mem_rdata;
          end
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_err <= 1'b1;
        end
        if (mem_rresp != 2'b00)                 r_err <= 1'b1;
        if (mem_rlast && r_cnt != c_LAST_BEAT) r_err <= 1'b1;
      end

      if (r_state == c_FLUSH) r_idx <= r_idx + 1'b1;
      else                    r_idx <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_friscv_icache_linefill.sv
// ============================================================================
// Module   : tb_friscv_icache_linefill
// Brief    : Scoreboard bench for the I-cache line-fill / flush engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_friscv_icache_linefill;

  logic         aclk = 1'b0;
  logic         aresetn, srst, flush_req, flush_ack, flushing;
  logic         miss_valid, miss_ready, miss_err;
  logic [31:0]  miss_addr;
  logic         mem_arvalid, mem_arready, mem_arlock;
  logic [31:0]  mem_araddr;
  logic [7:0]   mem_arlen;
  logic [2:0]   mem_arsize, mem_arprot;
  logic [1:0]   mem_arburst, mem_rresp;
  logic [3:0]   mem_arcache, mem_arqos, mem_arregion;
  logic [7:0]   mem_arid, mem_rid;
  logic         mem_rvalid, mem_rready, mem_rlast;
  logic [31:0]  mem_rdata;
  logic         cache_wen, cache_clr;
  logic [31:0]  cache_waddr;
  logic [127:0] cache_wdata;
  logic [2:0]   cache_clr_idx;

  typedef struct {
    logic         err;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   errors    = 0;
  int   checks    = 0;
  int   wen_count = 0;

  always #5 aclk = ~aclk;

  friscv_icache_linefill #(
    .XLEN(32), .ADDR_W(32), .AXI_ID_W(8), .AXI_ID(0),
    .AXI_DATA_W(32), .CACHE_LINE_W(128), .CACHE_DEPTH(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .flush_req(flush_req), .flush_ack(flush_ack), .flushing(flushing),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_err(miss_err),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_arlock(mem_arlock), .mem_arcache(mem_arcache), .mem_arprot(mem_arprot),
    .mem_arqos(mem_arqos), .mem_arregion(mem_arregion), .mem_arid(mem_arid),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rid(mem_rid),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .cache_clr(cache_clr), .cache_clr_idx(cache_clr_idx)
  );

  // Scoreboard consumer: every line write or fill error pops one expectation.
  always @(negedge aclk) begin
    if (cache_wen === 1'b1 || miss_err === 1'b1) begin
      checks++;
      if (cache_wen === 1'b1) wen_count++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: wen=%b err=%b waddr=%h, required no event", cache_wen, miss_err, cache_waddr);
      end else begin
        m_e = sb.pop_front();
        if (m_e.err) begin
          if (miss_err !== 1'b1 || cache_wen !== 1'b0) begin
            errors++;
            $display("FAIL sb_err: wen=%b err=%b, required wen=0 err=1", cache_wen, miss_err);
          end
        end else if (cache_wen !== 1'b1 || miss_err !== 1'b0 ||
                     cache_waddr !== m_e.addr || cache_wdata !== m_e.data) begin
          errors++;
          $display("FAIL sb_write: wen=%b err=%b addr=%h data=%h, required wen=1 err=0 addr=%h data=%h",
                   cache_wen, miss_err, cache_waddr, cache_wdata, m_e.addr, m_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({mem_arvalid, mem_rready, cache_wen, miss_err, flushing, cache_clr,
         flush_ack, miss_ready} !== 8'b0000_0001 || mem_araddr !== 32'h0 ||
        cache_wdata !== 128'h0 || mem_arlen !== 8'h0) begin
      errors++;
      $display("FAIL %s: arv=%b rr=%b wen=%b err=%b fl=%b clr=%b ack=%b rdy=%b araddr=%h, required all 0 and rdy=1",
               name, mem_arvalid, mem_rready, cache_wen, miss_err, flushing, cache_clr,
               flush_ack, miss_ready, mem_araddr);
    end
  endtask

  // One miss transaction with a behavioural AXI slave. abort_after>=0 resets
  // the DUT (rst_mode 1=aresetn, 2=srst) once that many beats were delivered.
  task automatic run_fill(input logic [31:0] addr, input logic [31:0] seed,
                          input int nbeats, input int bad_beat, input int ar_stall,
                          input int gap, input int flush_beat,
                          input int abort_after, input int rst_mode);
    exp_t e;
    int   n;
    e.addr = addr & ~32'hF;
    e.data = '0;
    for (int k = 0; k < nbeats && k < 4; k++) e.data[k*32 +: 32] = seed * (k + 1);
    e.err = (bad_beat >= 0) || (nbeats != 4);
    if (abort_after < 0) sb.push_back(e);

    @(negedge aclk);
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++; $display("FAIL miss_ready_idle: got %b, required 1", miss_ready);
    end
    miss_valid = 1'b1; miss_addr = addr;
    @(negedge aclk);
    miss_valid = 1'b0; miss_addr = '0;

    for (int i = 0; i <= ar_stall; i++) begin
      checks++;
      if (mem_arvalid !== 1'b1 || mem_araddr !== e.addr || mem_arlen !== 8'd3 ||
          mem_arsize !== 3'd2 || mem_arburst !== 2'b01 || mem_arid !== 8'h0 || miss_ready !== 1'b0) begin
        errors++;
        $display("FAIL ar_channel: arv=%b araddr=%h len=%0d size=%0d burst=%b id=%h rdy=%b, required 1 %h 3 2 01 00 0",
                 mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_arid, miss_ready, e.addr);
      end
      if (i == ar_stall) mem_arready = 1'b1;
      @(negedge aclk);
    end
    mem_arready = 1'b0;

    for (int k = 0; k < nbeats; k++) begin
      if (abort_after == k) begin
        if (rst_mode == 1) begin
          aresetn = 1'b0;
          #1 check_reset_outputs("async_reset_mid_burst");
          @(negedge aclk);
          aresetn = 1'b1;
        end else begin
          srst = 1'b1;
          @(negedge aclk);
          #1 check_reset_outputs("sync_reset_mid_burst");
          srst = 1'b0;
        end
        return;
      end
      repeat (gap) @(negedge aclk);
      if (k == flush_beat) flush_req = 1'b1;
      checks++;
      if (mem_rready !== 1'b1 || mem_arvalid !== 1'b0) begin
        errors++; $display("FAIL rready: rready=%b arvalid=%b, required 1 0", mem_rready, mem_arvalid);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = seed * (k + 1);
      mem_rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
      mem_rlast  = (k == nbeats - 1);
      @(negedge aclk);
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00; mem_rdata = '0;
    end

    @(negedge aclk);
    if (flush_beat >= 0) begin
      checks++;
      if (flushing !== 1'b1 || cache_clr !== 1'b1 || cache_clr_idx !== 3'd0) begin
        errors++;
        $display("FAIL flush_after_fill: fl=%b clr=%b idx=%0d, required 1 1 0", flushing, cache_clr, cache_clr_idx);
      end
      n = 0;
      while (flush_ack !== 1'b1 && n < 20) begin
        @(negedge aclk);
        n++;
      end
      checks++;
      if (flush_ack !== 1'b1 || n != 8) begin
        errors++; $display("FAIL flush_after_fill_ack: ack=%b cycles=%0d, required 1 8", flush_ack, n);
      end
      flush_req = 1'b0;
      @(negedge aclk);
    end
    #1;
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_fill: got %b, required 1", miss_ready);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; srst = 1'b0; flush_req = 1'b0; miss_valid = 1'b0; miss_addr = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rid = 8'h5A; mem_rresp = '0;
    mem_rdata = '0; mem_rlast = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset_state");
    aresetn = 1'b1;
    @(negedge aclk);
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_nominal();
    run_fill(32'h0000_1234, 32'h1111_1111, 4, -1, 0, 0, -1, -1, 0);
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = wen_count;
    run_fill(32'h0000_1234, 32'h1111_1111, 4, -1, 5, 2, -1, -1, 0);
    checks++;
    if (wen_count != n0 + 1) begin
      errors++; $display("FAIL backpressure_wen_count: got %0d, required %0d", wen_count - n0, 1);
    end
  endtask

  task automatic test_errors();
    run_fill(32'h0000_2008, 32'h0101_0101, 4, 1, 0, 0, -1, -1, 0);
    run_fill(32'h0000_3000, 32'h0A0B_0C0D, 4, -1, 0, 0, -1, -1, 0);
    run_fill(32'h0000_4004, 32'h1357_9BDF, 3, -1, 0, 0, -1, -1, 0);
    run_fill(32'h0000_500C, 32'h2468_ACE0, 5, -1, 0, 1, -1, -1, 0);
  endtask

  task automatic test_flush_idle();
    @(negedge aclk);
    flush_req = 1'b1;
    #1;
    checks++;
    if (miss_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready_low: got %b, required 0", miss_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      checks++;
      if (cache_clr !== 1'b1 || cache_clr_idx !== 3'(i) || flushing !== 1'b1 || flush_ack !== 1'b0) begin
        errors++;
        $display("FAIL flush_sweep: clr=%b idx=%0d fl=%b ack=%b, required 1 %0d 1 0",
                 cache_clr, cache_clr_idx, flushing, flush_ack, i);
      end
    end
    @(negedge aclk);
    checks++;
    if (flush_ack !== 1'b1 || flushing !== 1'b0 || cache_clr !== 1'b0) begin
      errors++; $display("FAIL flush_ack: ack=%b fl=%b clr=%b, required 1 0 0", flush_ack, flushing, cache_clr);
    end
    @(negedge aclk);
    checks++;
    if (flush_ack !== 1'b0 || flushing !== 1'b0 || miss_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_held_no_retrigger: ack=%b fl=%b rdy=%b, required 0 0 0", flush_ack, flushing, miss_ready);
    end
    flush_req = 1'b0;
    #1;
    checks++;
    if (miss_ready !== 1'b1) begin
      errors++; $display("FAIL flush_release_ready: got %b, required 1", miss_ready);
    end
  endtask

  task automatic test_flush_mid_fill();
    run_fill(32'h0000_6020, 32'h0F0F_0F0F, 4, -1, 1, 0, 1, -1, 0);
  endtask

  task automatic test_reset_mid_burst();
    run_fill(32'h0000_7010, 32'hDEAD_0001, 4, -1, 0, 0, -1, 2, 1);
    run_fill(32'h0000_8030, 32'h0BAD_0003, 4, -1, 0, 0, -1, -1, 0);
    run_fill(32'h0000_9040, 32'hCAFE_0005, 4, -1, 0, 0, -1, 2, 2);
    run_fill(32'h0000_A050, 32'h1234_0007, 4, -1, 0, 0, -1, -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_fill(32'h0001_0000 + 32'($urandom_range(0, 4095)), $urandom, 4, -1,
               $urandom_range(0, 2), $urandom_range(0, 1), -1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_errors();
    test_flush_idle();
    test_flush_mid_fill();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (2) @(negedge aclk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/friscv_icache_linefill.md
Name: friscv_icache_linefill

Overview:
- Miss-driven line-fill engine for the instruction cache, sitting between the cache lookup stage and the AXI4 read channels to central memory.
- Accepts one line-miss request at a time and issues a single INCR burst covering a full cache line.
- Assembles the returned beats into a line and writes it into the cache RAM.
- Also runs the cache flush: sweeps every line index and clears its valid bit, then acknowledges.

Parameters:
- XLEN, 32, architecture word width.
- ADDR_W, 32, byte address width for the miss interface and AXI.
- AXI_ID_W, 8, AXI ID width.
- AXI_ID, 0, constant ID driven on mem_arid.
- AXI_DATA_W, 32, AXI read data width. Power of two; must be ≤ CACHE_LINE_W.
- CACHE_LINE_W, 128, line payload width in bits. Power-of-two multiple of AXI_DATA_W.
- CACHE_DEPTH, 512, number of lines. Power of two.
- Derived: NB_BEATS = CACHE_LINE_W/AXI_DATA_W; LINE_OFF_W = log2(CACHE_LINE_W/8); IDX_W = log2(CACHE_DEPTH).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset, same effect as aresetn
- flush_req  in  1  level; request full cache invalidation
- flush_ack  out  1  one-cycle pulse when the sweep completes
- flushing  out  1  high while the flush sweep runs
- miss_valid  in  1  line-miss request
- miss_ready  out  1  request accepted when valid & ready
- miss_addr  in  ADDR_W  byte address of the missing instruction
- miss_err  out  1  one-cycle pulse: fill failed (bad RRESP or beat-count mismatch)
- mem_ar*  out  AXI4 AR channel (valid, addr, len, size, burst, lock, cache, prot, qos, region, id); mem_arready in
- mem_r*  in  AXI4 R channel (valid, id, resp, data, last); mem_rready out
- cache_wen  out  1  line write strobe
- cache_waddr  out  ADDR_W  line-aligned byte address of the written line
- cache_wdata  out  CACHE_LINE_W  assembled line
- cache_clr  out  1  clear valid bit of line cache_clr_idx
- cache_clr_idx  out  IDX_W  line index being cleared

Behaviour:
- Fixed AXI fields:
  - arburst = INCR (2'b01), arlen = NB_BEATS-1, arsize = log2(AXI_DATA_W/8).
  - arid = AXI_ID.
  - lock, cache, prot, qos, region = 0.
- Reset (aresetn low asynchronously, or srst high at a clock edge):
  - FSM returns to IDLE.
  - All outputs are 0 except miss_ready, which is 1.
  - Beat counter, line buffer and error flag are cleared.
  - A burst in flight at reset is abandoned; its beats are not consumed after reset. System reset is expected to reset memory too.
- IDLE:
  - miss_ready = !flush_req.
  - flush_req has priority: go to FLUSH with index 0.
  - Otherwise, on miss_valid & miss_ready, register the address with its low LINE_OFF_W bits zeroed, then go to AR.
- AR:
  - mem_arvalid = 1 and mem_araddr = registered aligned address, both stable until mem_arready.
  - On the handshake, go to RDATA.
- RDATA:
  - mem_rready = 1.
  - Each beat k (0-based) is written to line buffer bits [k*AXI_DATA_W +: AXI_DATA_W].
  - The error flag sets if rresp != 0 on any beat.
  - On the rlast beat, the error flag also sets if the beat count is not NB_BEATS; then go to WRITE.
  - A beat beyond NB_BEATS without rlast: data is dropped, the error flag sets, and the block waits for rlast.
- WRITE (one cycle):
  - Error flag clear: cache_wen = 1, with cache_waddr = aligned address and cache_wdata = buffer.
  - Error flag set: cache_wen = 0 and miss_err pulses.
  - Then go to IDLE, or to FLUSH if flush_req is high.
- FLUSH:
  - flushing = 1 and cache_clr = 1, with cache_clr_idx stepping 0..CACHE_DEPTH-1, one index per cycle.
  - After the last index, flush_ack pulses for 1 cycle on the following cycle with flushing = 0, then go to IDLE.
  - flush_req may stay high through the ack. A new flush starts only after flush_req is seen low, then high again (edge-armed).
- Flush requested during AR or RDATA: the fill completes and the line is written in WRITE, then FLUSH runs, so that line is also invalidated.
- Latency:
  - mem_arvalid rises 1 cycle after miss acceptance.
  - cache_wen fires 1 cycle after the rlast beat.
  - Total flush duration is CACHE_DEPTH+1 cycles from entering FLUSH to flush_ack.
- miss_ready is low in every state except IDLE, so only one fill is outstanding at a time.
- rid is ignored.

Test Plan:
- Nominal fill (AXI_DATA_W=32, CACHE_LINE_W=128): miss_addr=0x1234 → araddr=0x1230, arlen=3, arsize=2. Beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on 4th) → one cache_wen with waddr=0x1230 and wdata=0x44444444_33333333_22222222_11111111; miss_ready high again the next cycle.
- Backpressure: arready held low 5 cycles, then rvalid gaps between beats → araddr stable throughout; same wdata; exactly one cache_wen.
- Error: rresp=2'b10 on beat 1 → no cache_wen; miss_err pulses once; next miss is accepted normally.
- Short burst: rlast on beat 2 (3 beats) → miss_err pulses; no cache_wen.
- Flush with CACHE_DEPTH=8: flush_req in IDLE → cache_clr indices 0..7 on 8 consecutive cycles, then flush_ack for 1 cycle; miss_ready = 0 while flush_req is high. Flush raised mid-RDATA → line written first, then the sweep.
- Reset mid-burst: aresetn low after beat 1 → all outputs 0 and miss_ready = 1 immediately. After release, a new miss yields correct wdata with no stale beats. Repeat using srst.
